// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding,
// iteration count and two's-complement helpers.
package div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam logic [4:0]  LAST_ITER = 5'(DIV_ITERS - 1);

  // Two's-complement negation.
  function automatic logic [DATA_W-1:0] neg2c(input logic [DATA_W-1:0] v);
    return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of v when it is to be read as signed, otherwise v unchanged.
  function automatic logic [DATA_W-1:0] abs_if(input logic [DATA_W-1:0] v, input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? neg2c(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the result if no
// borrow occurred, shifting the resulting quotient bit into the low end.
module div_step
  import div_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dsr_i,
  output logic [W:0]   rem_o,
  output logic [W-1:0] quo_o
);

  logic [W+1:0] shift_s;
  logic [W+1:0] diff_s;

  // Trial subtract; the top bit of diff_s is the borrow.
  always_comb begin
    shift_s = {rem_i, quo_i[W-1]};
    diff_s  = shift_s - {2'b00, dsr_i};
    if (!diff_s[W+1]) begin
      rem_o = diff_s[W:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end else begin
      rem_o = shift_s[W:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider (restoring, one bit per cycle).
// Optional macro DIV_UNIT_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow skip the iteration loop and go straight to the fix-up state.
// The accepted request is held for one cycle in req_q while the operand
// magnitudes are formed, so RUN starts on the edge after acceptance.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic            sgn,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem,
  output logic            dbz
);

`ifdef DIV_UNIT_FAST_SPECIAL_EN
  localparam logic FAST_SPECIAL = 1'b1;
`else
  localparam logic FAST_SPECIAL = 1'b0;
`endif

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            sgn_q, sgn_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   acc_q, acc_d;
  logic [XLEN-1:0] qr_q, qr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [XLEN-1:0] dsr_s;
  logic [XLEN:0]   step_rem_s;
  logic [XLEN-1:0] step_quo_s;
  logic            dbz_s, ovf_s, neg_quo_s, neg_rem_s;

  assign dsr_s     = abs_if(dvs_q, sgn_q);
  assign dbz_s     = (dvs_q == '0);
  assign ovf_s     = sgn_q & (dvd_q == MIN_NEG) & (dvs_q == '1);
  assign neg_quo_s = sgn_q & (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
  assign neg_rem_s = sgn_q & dvd_q[XLEN-1];

  div_step #(.W(XLEN)) u_step (
    .rem_i (acc_q),
    .quo_i (qr_q),
    .dsr_i (dsr_s),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  // Next-state and datapath control; kill overrides everything but reset.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    if (kill) begin
      state_d = IDLE;
      req_d   = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_q) begin
            req_d = 1'b0;
            if (FAST_SPECIAL && (dbz_s || ovf_s)) begin
              state_d = FIX;
              acc_d   = '0;
              qr_d    = dbz_s ? '1 : MIN_NEG;
            end else begin
              state_d = RUN;
              acc_d   = '0;
              qr_d    = abs_if(dvd_q, sgn_q);
              cnt_d   = 5'd0;
            end
          end else if (start) begin
            req_d  = 1'b1;
            busy_d = 1'b1;
            sgn_d  = sgn;
            dvd_d  = dividend;
            dvs_d  = divisor;
          end else begin
            req_d = 1'b0;
          end
        end
        RUN: begin
          acc_d = step_rem_s;
          qr_d  = step_quo_s;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            state_d = FIX;
          end else begin
            state_d = RUN;
          end
        end
        FIX: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = dbz_s;
          if (dbz_s) begin
            quot_d = '1;
            rem_d  = dvd_q;
          end else begin
            quot_d = neg_quo_s ? neg2c(qr_q) : qr_q;
            rem_d  = neg_rem_s ? neg2c(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      qr_q    <= '0;
      cnt_q   <= 5'd0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign dbz  = dbz_q;

endmodule
